// File: rtl/clock_period_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : clock_period_monitor
//  Purpose  : Receive-side checker for a divided clock. Synchronizes the
//             monitored clock into the clock_in domain, measures every
//             half-period in clock_in cycles, declares lock after a run of
//             in-tolerance half-periods, counts bad half-periods and flags a
//             stalled clock.
//  Ports    : clock_in     - system clock, all logic on its rising edge
//             reset        - synchronous, active-low, clears all state
//             enable       - monitor enable (low forces IDLE)
//             sense_in     - monitored clock, asynchronous to clock_in
//             edge_pulse   - one-cycle pulse per synchronized edge (any polarity)
//             period_valid - one-cycle pulse when half_period is updated
//             half_period  - last measured half-period (clock_in cycles)
//             locked       - LOCK_COUNT or more consecutive good half-periods
//             stuck        - no edge seen for TIMEOUT cycles
//             err_count    - saturating count of bad half-periods
//  Revision : 1.0 - initial release
// ============================================================================
module clock_period_monitor #(
   parameter int HALF_PERIOD = 5,
   parameter int TOL         = 1,
   parameter int LOCK_COUNT  = 8,
   parameter int TIMEOUT     = 64,
   parameter int CNT_W       = 12
) (
   input  logic             clock_in,
   input  logic             reset,
   input  logic             enable,
   input  logic             sense_in,
   output logic             edge_pulse,
   output logic             period_valid,
   output logic [CNT_W-1:0] half_period,
   output logic             locked,
   output logic             stuck,
   output logic [7:0]       err_count
);

   // Tolerance window, one bit wider than the counter so HALF_PERIOD+TOL
   // can never wrap.
   localparam int               c_LO_I    = (HALF_PERIOD > TOL) ? (HALF_PERIOD - TOL) : 0;
   localparam int               c_HI_I    = HALF_PERIOD + TOL;
   localparam logic [CNT_W:0]   c_LO      = (CNT_W+1)'(c_LO_I);
   localparam logic [CNT_W:0]   c_HI      = (CNT_W+1)'(c_HI_I);
   localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
   localparam logic [7:0]       c_LOCK    = 8'(LOCK_COUNT);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SEEK    = 2'd1,
      S_MEASURE = 2'd2,
      S_LOCKED  = 2'd3
   } state_t;

   state_t           r_state, w_nxt_state;
   logic             r_s1, r_s2, r_s3;
   logic             r_edge_pulse;
   logic             r_pv, w_nxt_pv;
   logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
   logic [CNT_W-1:0] r_hp, w_nxt_hp;
   logic [7:0]       r_run, w_nxt_run;
   logic [7:0]       r_err, w_nxt_err;
   logic             r_stuck, w_nxt_stuck;

   logic             w_edge;
   logic             w_good;
   logic             w_timeout;
   logic [CNT_W-1:0] w_cnt_inc;
   logic [7:0]       w_run_inc;
   logic [7:0]       w_err_inc;

   // s2 vs. its one-cycle history gives a pulse on either polarity.
   assign w_edge    = r_s2 ^ r_s3;
   // Judged on the pre-edge count, i.e. the length of the interval just ended.
   assign w_good    = ({1'b0, r_cnt} >= c_LO) && ({1'b0, r_cnt} <= c_HI);
   assign w_timeout = (r_cnt == c_TIMEOUT);
   assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : (r_cnt + CNT_W'(1));
   assign w_run_inc = r_run + 8'd1;
   assign w_err_inc = (r_err == 8'hFF) ? r_err : (r_err + 8'd1);

   always_ff @(posedge clock_in) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_s1         <= 1'b0;
         r_s2         <= 1'b0;
         r_s3         <= 1'b0;
         r_edge_pulse <= 1'b0;
         r_pv         <= 1'b0;
         r_cnt        <= '0;
         r_hp         <= '0;
         r_run        <= 8'd0;
         r_err        <= 8'd0;
         r_stuck      <= 1'b0;
      end else begin
         r_state      <= w_nxt_state;
         r_s1         <= sense_in;
         r_s2         <= r_s1;
         r_s3         <= r_s2;
         r_edge_pulse <= w_edge;
         r_pv         <= w_nxt_pv;
         r_cnt        <= w_nxt_cnt;
         r_hp         <= w_nxt_hp;
         r_run        <= w_nxt_run;
         r_err        <= w_nxt_err;
         r_stuck      <= w_nxt_stuck;
      end
   end

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_pv    = 1'b0;
      w_nxt_cnt   = w_edge ? CNT_W'(1) : w_cnt_inc;
      w_nxt_hp    = r_hp;
      w_nxt_run   = r_run;
      w_nxt_err   = r_err;
      w_nxt_stuck = r_stuck;

      if (!enable) begin
         // Disable wins from any state; measurement history is kept.
         w_nxt_state = S_IDLE;
         w_nxt_cnt   = '0;
         w_nxt_run   = 8'd0;
         w_nxt_stuck = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_nxt_state = S_SEEK;
               w_nxt_cnt   = '0;
               w_nxt_run   = 8'd0;
               w_nxt_stuck = 1'b0;
            end
            S_SEEK: begin
               if (w_edge) begin
                  // Interval before the first edge is partial: not measured.
                  w_nxt_state = S_MEASURE;
                  w_nxt_stuck = 1'b0;
               end else if (w_timeout) begin
                  w_nxt_stuck = 1'b1;
                  w_nxt_run   = 8'd0;
               end
            end
            S_MEASURE, S_LOCKED: begin
               if (w_edge) begin
                  w_nxt_pv = 1'b1;
                  w_nxt_hp = r_cnt;
                  if (w_good) begin
                     if (r_state == S_MEASURE) begin
                        w_nxt_run = w_run_inc;
                        if (w_run_inc >= c_LOCK) begin
                           w_nxt_state = S_LOCKED;
                        end
                     end
                  end else begin
                     w_nxt_state = S_MEASURE;
                     w_nxt_run   = 8'd0;
                     w_nxt_err   = w_err_inc;
                  end
               end else if (w_timeout) begin
                  // Edge has priority, so this only fires on a silent cycle.
                  w_nxt_state = S_SEEK;
                  w_nxt_stuck = 1'b1;
                  w_nxt_run   = 8'd0;
               end
            end
            default: begin
               w_nxt_state = S_IDLE;
            end
         endcase
      end
   end

   assign edge_pulse   = r_edge_pulse;
   assign period_valid = r_pv;
   assign half_period  = r_hp;
   assign locked       = (r_state == S_LOCKED);
   assign stuck        = r_stuck;
   assign err_count    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_clock_period_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clock_period_monitor
//  Purpose  : Self-checking bench for clock_period_monitor. Stimulus toggles
//             sense_in at chosen intervals and pushes the expected response of
//             every edge (and every stall) into a queue; a monitor pops and
//             compares whenever the DUT pulses edge_pulse or raises stuck.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clock_period_monitor;

   localparam int HP   = 5;
   localparam int TL   = 1;
   localparam int LCK  = 8;
   localparam int TMO  = 64;
   localparam int CW   = 12;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic          sense_in = 1'b0;
   logic          edge_pulse;
   logic          period_valid;
   logic [CW-1:0] half_period;
   logic          locked;
   logic          stuck;
   logic [7:0]    err_count;

   clock_period_monitor #(
      .HALF_PERIOD (HP),
      .TOL         (TL),
      .LOCK_COUNT  (LCK),
      .TIMEOUT     (TMO),
      .CNT_W       (CW)
   ) dut (
      .clock_in     (clk),
      .reset        (rst_n),
      .enable       (enable),
      .sense_in     (sense_in),
      .edge_pulse   (edge_pulse),
      .period_valid (period_valid),
      .half_period  (half_period),
      .locked       (locked),
      .stuck        (stuck),
      .err_count    (err_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests  = 0;
   int failed = 0;

   task automatic chk(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         failed++;
         $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // ---------------- reference model (edge-level behaviour) ----------------
   typedef struct {
      bit is_stuck;
      bit pv;
      int hp;
      bit lk;
      int err;
   } exp_t;

   exp_t q[$];

   bit m_seeking = 1'b1;
   bit m_locked  = 1'b0;
   bit m_stuck   = 1'b0;
   int m_run     = 0;
   int m_err     = 0;
   int m_hp      = 0;
   int last_n    = 0;

   task automatic m_reset();
      m_seeking = 1'b1; m_locked = 1'b0; m_stuck = 1'b0;
      m_run = 0; m_err = 0; m_hp = 0; last_n = 0;
   endtask

   task automatic m_idle();
      m_seeking = 1'b1; m_locked = 1'b0; m_stuck = 1'b0; m_run = 0;
   endtask

   // One edge that closes an interval of 'gap' cycles, with enable = en.
   task automatic model_edge(input int gap, input bit en);
      exp_t e;
      e.is_stuck = 1'b0;
      e.pv       = 1'b0;
      if (!en) begin
         m_idle();
      end else if (m_seeking) begin
         m_seeking = 1'b0;
         m_stuck   = 1'b0;
      end else begin
         e.pv = 1'b1;
         m_hp = gap;
         if (gap >= HP - TL && gap <= HP + TL) begin
            if (!m_locked) begin
               m_run++;
               if (m_run >= LCK) m_locked = 1'b1;
            end
         end else begin
            m_run    = 0;
            m_locked = 1'b0;
            if (m_err < 255) m_err++;
         end
      end
      e.hp  = m_hp;
      e.lk  = m_locked;
      e.err = m_err;
      q.push_back(e);
   endtask

   // Toggle sense_in now, then hold it for n cycles.
   task automatic drive(input int n, input bit en);
      exp_t e;
      enable   = en;
      sense_in = ~sense_in;
      model_edge(last_n, en);
      last_n = n;
      // A silent interval longer than the timeout stalls the monitor
      // before the next edge arrives.
      if (en && !m_seeking && n > TMO) begin
         m_seeking = 1'b1; m_stuck = 1'b1; m_locked = 1'b0; m_run = 0;
         e.is_stuck = 1'b1; e.pv = 1'b0; e.hp = m_hp; e.lk = 1'b0; e.err = m_err;
         q.push_back(e);
      end
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------------------- monitor ------------------------------------
   initial begin
      exp_t e;
      bit   prev_stuck;
      int   last_edge_cyc;
      prev_stuck    = 1'b0;
      last_edge_cyc = 0;
      forever begin
         @(negedge clk);
         if (edge_pulse === 1'b1) begin
            if (q.size() == 0) begin
               chk("unexpected_edge", 1, 0);
            end else begin
               e = q.pop_front();
               chk("edge_kind_is_stuck", 0, int'(e.is_stuck));
               chk("period_valid", int'(period_valid), int'(e.pv));
               chk("half_period", int'(half_period), e.hp);
               chk("locked", int'(locked), int'(e.lk));
               chk("err_count", int'(err_count), e.err);
               chk("stuck_at_edge", int'(stuck), 0);
            end
            last_edge_cyc = cyc;
         end
         if (stuck === 1'b1 && !prev_stuck) begin
            if (q.size() == 0) begin
               chk("unexpected_stuck", 1, 0);
            end else begin
               e = q.pop_front();
               chk("stuck_kind", 1, int'(e.is_stuck));
               chk("stuck_delay", cyc - last_edge_cyc, TMO);
               chk("locked_at_stuck", int'(locked), 0);
               chk("half_period_at_stuck", int'(half_period), e.hp);
            end
         end
         prev_stuck = (stuck === 1'b1);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------- stimulus -----------------------------------
   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_edge_pulse", int'(edge_pulse), 0);
      chk("rst_period_valid", int'(period_valid), 0);
      chk("rst_half_period", int'(half_period), 0);
      chk("rst_locked", int'(locked), 0);
      chk("rst_stuck", int'(stuck), 0);
      chk("rst_err_count", int'(err_count), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Nominal lock at exactly the expected half-period.
      for (int i = 0; i < 20; i++) drive(HP, 1'b1);
      chk("nominal_locked", int'(locked), 1);
      chk("nominal_err", int'(err_count), 0);

      // Tolerance limits, then single outliers while locked.
      for (int i = 0; i < 16; i++) drive((i % 2 == 0) ? 4 : 6, 1'b1);
      drive(3, 1'b1);
      for (int i = 0; i < 10; i++) drive(HP, 1'b1);
      drive(7, 1'b1);
      for (int i = 0; i < 10; i++) drive(HP, 1'b1);

      // Stall while locked, then resume.
      drive(80, 1'b1);
      for (int i = 0; i < 12; i++) drive(HP, 1'b1);

      // Enable drop while locked.
      enable = 1'b0;
      m_idle();
      @(posedge clk); #1;
      chk("drop_locked", int'(locked), 0);
      chk("drop_hp_kept", int'(half_period), m_hp);
      chk("drop_err_kept", int'(err_count), m_err);
      for (int i = 0; i < 3; i++) drive(HP, 1'b0);
      for (int i = 0; i < 12; i++) drive(HP, 1'b1);

      // Randomized intervals, including the timeout boundary and stalls.
      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 19))
            0:       n = 70;
            1:       n = TMO;
            default: n = int'($urandom_range(3, 7));
         endcase
         drive(n, $urandom_range(0, 9) != 0);
      end
      for (int i = 0; i < 12; i++) drive(HP, 1'b1);

      // Reset mid-operation with sense_in settled low.
      if (sense_in) drive(HP, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_reset();
      chk("mid_rst_edge_pulse", int'(edge_pulse), 0);
      chk("mid_rst_period_valid", int'(period_valid), 0);
      chk("mid_rst_half_period", int'(half_period), 0);
      chk("mid_rst_locked", int'(locked), 0);
      chk("mid_rst_stuck", int'(stuck), 0);
      chk("mid_rst_err_count", int'(err_count), 0);
      for (int i = 0; i < 12; i++) drive(HP, 1'b1);
      chk("relock_after_reset", int'(locked), 1);

      // Out of tolerance forever: never locks, errors saturate.
      for (int i = 0; i < 262; i++) drive(7, 1'b1);
      chk("sat_err_count", int'(err_count), 255);
      chk("sat_locked", int'(locked), 0);

      repeat (6) @(posedge clk);
      #1;
      chk("queue_drained", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
`default_nettype wire
